// File: rtl/drp_reconf_master.sv
`default_nettype none
// ============================================================================
// Module   : drp_reconf_master
// Purpose  : DRP master that walks a loadable (addr, mask, data) table and
//            read-modify-writes each PLL register while holding PLL reset.
// Revision : 1.0 - initial release
// ============================================================================
module drp_reconf_master #(
  parameter int DEPTH        = 23,
  parameter int IDX_W        = 5,
  parameter int DRDY_TIMEOUT = 64,
  parameter int LOCK_TIMEOUT = 4096
) (
  input  logic             DCLK,
  input  logic             RST,
  input  logic             SEN,
  input  logic [IDX_W:0]   NUM_ENTRIES,
  input  logic             TBL_WE,
  input  logic [IDX_W-1:0] TBL_IDX,
  input  logic [6:0]       TBL_ADDR,
  input  logic [15:0]      TBL_MASK,
  input  logic [15:0]      TBL_DATA,
  output logic [6:0]       DADDR,
  output logic             DEN,
  output logic             DWE,
  output logic [15:0]      DI,
  input  logic [15:0]      DO,
  input  logic             DRDY,
  output logic             PLL_RST,
  input  logic             LOCKED,
  output logic             BUSY,
  output logic             SRDY,
  output logic             ERR
);

  localparam int c_CNT_MAX = (DRDY_TIMEOUT > LOCK_TIMEOUT) ? DRDY_TIMEOUT : LOCK_TIMEOUT;
  localparam int c_CNT_W   = $clog2(c_CNT_MAX) + 1;

  localparam logic [c_CNT_W-1:0] c_DRDY_LAST = c_CNT_W'(DRDY_TIMEOUT - 1);
  localparam logic [c_CNT_W-1:0] c_LOCK_LAST = c_CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [c_CNT_W-1:0] c_GUARD_END = c_CNT_W'(2);
  localparam logic [c_CNT_W-1:0] c_LOCK_MIN  = c_CNT_W'(1);
  localparam logic [IDX_W:0]     c_DEPTH_N   = (IDX_W + 1)'(DEPTH);

  localparam logic [3:0] c_ST_IDLE       = 4'd0;
  localparam logic [3:0] c_ST_ASSERT_RST = 4'd1;
  localparam logic [3:0] c_ST_READ_REQ   = 4'd2;
  localparam logic [3:0] c_ST_READ_WAIT  = 4'd3;
  localparam logic [3:0] c_ST_WRITE_REQ  = 4'd4;
  localparam logic [3:0] c_ST_WRITE_WAIT = 4'd5;
  localparam logic [3:0] c_ST_NEXT       = 4'd6;
  localparam logic [3:0] c_ST_WAIT_LOCK  = 4'd7;
  localparam logic [3:0] c_ST_DONE       = 4'd8;

  logic [3:0]         r_state;
  logic [3:0]         w_next;
  logic               w_fail;
  logic [IDX_W-1:0]   r_idx;
  logic [IDX_W:0]     r_num;
  logic [c_CNT_W-1:0] r_cnt;
  logic [15:0]        r_rdata;
  logic               r_err;

  logic [6:0]  r_tbl_addr [DEPTH];
  logic [15:0] r_tbl_mask [DEPTH];
  logic [15:0] r_tbl_data [DEPTH];

  logic        w_num_ok;
  logic        w_drp_done;
  logic        w_last;
  logic [6:0]  w_entry_addr;
  logic [15:0] w_wdata;

  assign w_num_ok     = (NUM_ENTRIES != '0) && (NUM_ENTRIES <= c_DEPTH_N);
  // The first wait cycle (r_cnt == 1) is a guard cycle; DRDY there is ignored.
  assign w_drp_done   = DRDY && (r_cnt >= c_GUARD_END);
  assign w_last       = ({1'b0, r_idx} == (r_num - 1'b1));
  assign w_entry_addr = r_tbl_addr[r_idx];
  assign w_wdata      = (r_rdata & r_tbl_mask[r_idx]) | r_tbl_data[r_idx];

  always_ff @(posedge DCLK) begin
    if (RST) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    w_fail = 1'b0;
    case (r_state)
      c_ST_IDLE:       if (SEN && w_num_ok) w_next = c_ST_ASSERT_RST;
      c_ST_ASSERT_RST: w_next = c_ST_READ_REQ;
      c_ST_READ_REQ:   w_next = c_ST_READ_WAIT;
      c_ST_READ_WAIT: begin
        if (w_drp_done) begin
          w_next = c_ST_WRITE_REQ;
        end else if (r_cnt == c_DRDY_LAST) begin
          w_next = c_ST_IDLE;
          w_fail = 1'b1;
        end
      end
      c_ST_WRITE_REQ:  w_next = c_ST_WRITE_WAIT;
      c_ST_WRITE_WAIT: begin
        if (w_drp_done) begin
          w_next = c_ST_NEXT;
        end else if (r_cnt == c_DRDY_LAST) begin
          w_next = c_ST_IDLE;
          w_fail = 1'b1;
        end
      end
      c_ST_NEXT:       w_next = w_last ? c_ST_WAIT_LOCK : c_ST_READ_REQ;
      c_ST_WAIT_LOCK: begin
        if (LOCKED && (r_cnt >= c_LOCK_MIN)) begin
          w_next = c_ST_DONE;
        end else if (r_cnt == c_LOCK_LAST) begin
          w_next = c_ST_IDLE;
          w_fail = 1'b1;
        end
      end
      c_ST_DONE:       w_next = c_ST_IDLE;
      default:         w_next = c_ST_IDLE;
    endcase
  end

  always_ff @(posedge DCLK) begin
    if (RST) begin
      r_idx   <= '0;
      r_num   <= '0;
      r_cnt   <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if ((r_state == c_ST_IDLE) && SEN) begin
        if (w_num_ok) begin
          r_err <= 1'b0;
          r_num <= NUM_ENTRIES;
          r_idx <= '0;
        end else begin
          r_err <= 1'b1;
        end
      end
      if (w_fail) r_err <= 1'b1;
      if ((r_state == c_ST_READ_WAIT) && w_drp_done) r_rdata <= DO;
      if ((r_state == c_ST_NEXT) && !w_last) r_idx <= r_idx + 1'b1;
      // Counter restarts on each strobe and on lock-wait entry so both timeouts share it.
      if ((w_next != r_state) && ((w_next == c_ST_READ_REQ) || (w_next == c_ST_WRITE_REQ) ||
                                  (w_next == c_ST_WAIT_LOCK))) begin
        r_cnt <= '0;
      end else if (r_state != c_ST_IDLE) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge DCLK) begin
    if ((r_state == c_ST_IDLE) && TBL_WE && ({1'b0, TBL_IDX} < c_DEPTH_N)) begin
      r_tbl_addr[TBL_IDX] <= TBL_ADDR;
      r_tbl_mask[TBL_IDX] <= TBL_MASK;
      r_tbl_data[TBL_IDX] <= TBL_DATA;
    end
  end

  always_comb begin
    DEN     = 1'b0;
    DWE     = 1'b0;
    DADDR   = '0;
    DI      = '0;
    PLL_RST = 1'b0;
    BUSY    = (r_state != c_ST_IDLE);
    SRDY    = 1'b0;
    ERR     = r_err;
    case (r_state)
      c_ST_ASSERT_RST: PLL_RST = 1'b1;
      c_ST_READ_REQ: begin
        PLL_RST = 1'b1;
        DEN     = 1'b1;
        DADDR   = w_entry_addr;
      end
      c_ST_READ_WAIT: begin
        PLL_RST = 1'b1;
        DADDR   = w_entry_addr;
      end
      c_ST_WRITE_REQ: begin
        PLL_RST = 1'b1;
        DEN     = 1'b1;
        DWE     = 1'b1;
        DADDR   = w_entry_addr;
        DI      = w_wdata;
      end
      c_ST_WRITE_WAIT: begin
        PLL_RST = 1'b1;
        DWE     = 1'b1;
        DADDR   = w_entry_addr;
        DI      = w_wdata;
      end
      c_ST_NEXT:       PLL_RST = 1'b1;
      c_ST_DONE:       SRDY = 1'b1;
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_drp_reconf_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_drp_reconf_master
// Purpose  : Scoreboard bench for drp_reconf_master with a DRP slave model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_drp_reconf_master;

  localparam int c_MODE_NORMAL = 0;
  localparam int c_MODE_ZERO   = 1;
  localparam int c_MODE_ONE    = 2;

  logic        DCLK = 1'b0;
  logic        RST, SEN, TBL_WE, DRDY, LOCKED;
  logic [5:0]  NUM_ENTRIES;
  logic [4:0]  TBL_IDX;
  logic [6:0]  TBL_ADDR;
  logic [15:0] TBL_MASK, TBL_DATA, DO;
  logic [6:0]  DADDR;
  logic        DEN, DWE, PLL_RST, BUSY, SRDY, ERR;
  logic [15:0] DI;

  typedef struct packed {
    logic        we;
    logic [6:0]  addr;
    logic [15:0] di;
  } drp_t;

  drp_t        exp_q[$];
  logic [15:0] mem    [128];
  logic [15:0] shadow [128];
  logic [6:0]  m_addr [23];
  logic [15:0] m_mask [23];
  logic [15:0] m_data [23];
  int          n_checks = 0;
  int          n_errors = 0;
  int          rdy_mode = c_MODE_NORMAL;
  int          den_cnt  = 0;
  int          srdy_cnt = 0;
  int          stage    = 0;
  int          lk       = 0;

  drp_reconf_master dut (
    .DCLK(DCLK), .RST(RST), .SEN(SEN), .NUM_ENTRIES(NUM_ENTRIES),
    .TBL_WE(TBL_WE), .TBL_IDX(TBL_IDX), .TBL_ADDR(TBL_ADDR),
    .TBL_MASK(TBL_MASK), .TBL_DATA(TBL_DATA),
    .DADDR(DADDR), .DEN(DEN), .DWE(DWE), .DI(DI), .DO(DO), .DRDY(DRDY),
    .PLL_RST(PLL_RST), .LOCKED(LOCKED), .BUSY(BUSY), .SRDY(SRDY), .ERR(ERR)
  );

  always #5 DCLK = ~DCLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // DRP slave: DRDY rises on the second wait cycle in normal mode.
  always @(negedge DCLK) begin
    drp_t e;
    if (rdy_mode == c_MODE_NORMAL) begin
      DRDY = 1'b0;
      if (stage == 2) begin
        DRDY  = 1'b1;
        stage = 0;
      end else if (stage == 1) begin
        stage = 2;
      end
    end else begin
      DRDY = (rdy_mode == c_MODE_ONE);
    end
    if (DEN) begin
      den_cnt++;
      chk("pll_rst_during_drp", PLL_RST, 1);
      chk("drp_expected", (exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("drp_we", DWE, e.we);
        chk("drp_addr", DADDR, e.addr);
        if (e.we) chk("drp_di", DI, e.di);
      end
      if (DWE) mem[DADDR] = DI;
      else     DO = mem[DADDR];
      stage = 1;
    end
  end

  // PLL lock model: locks three cycles after reset is released.
  always @(negedge DCLK) begin
    if (PLL_RST || RST) begin
      LOCKED = 1'b0;
      lk     = 0;
    end else if (lk < 3) begin
      lk++;
    end else begin
      LOCKED = 1'b1;
    end
  end

  always @(negedge DCLK) begin
    if (SRDY) begin
      srdy_cnt++;
      chk("srdy_after_locked", LOCKED, 1);
    end
  end

  task automatic tbl_write(input int idx, input logic [6:0] a, input logic [15:0] m, input logic [15:0] d);
    @(negedge DCLK);
    TBL_WE = 1'b1; TBL_IDX = 5'(idx); TBL_ADDR = a; TBL_MASK = m; TBL_DATA = d;
    @(negedge DCLK);
    TBL_WE = 1'b0;
    m_addr[idx] = a; m_mask[idx] = m; m_data[idx] = d;
  endtask

  task automatic preload(input logic [6:0] a, input logic [15:0] v);
    mem[a]    = v;
    shadow[a] = v;
  endtask

  task automatic push_rmw(input int n);
    for (int i = 0; i < n; i++) begin
      logic [15:0] nv;
      exp_q.push_back('{we: 1'b0, addr: m_addr[i], di: 16'h0});
      nv = (shadow[m_addr[i]] & m_mask[i]) | m_data[i];
      shadow[m_addr[i]] = nv;
      exp_q.push_back('{we: 1'b1, addr: m_addr[i], di: nv});
    end
  endtask

  task automatic run(input int n, input int bound, output int f_den, output int s_den, output int l_busy);
    @(negedge DCLK);
    NUM_ENTRIES = 6'(n);
    SEN = 1'b1;
    @(negedge DCLK);
    SEN = 1'b0;
    f_den = -1; s_den = -1; l_busy = -1;
    for (int i = 0; i < bound; i++) begin
      if (DEN) begin
        if (f_den < 0) f_den = i;
        else if (s_den < 0) s_den = i;
      end
      if (!BUSY) break;
      l_busy = i;
      @(negedge DCLK);
    end
    chk("run_within_bound", BUSY, 0);
  endtask

  function automatic int clk_div(input logic [15:0] r1, input logic [15:0] r2);
    if (r2[6]) return 1;
    return int'(r1[11:6]) + int'(r1[5:0]);
  endfunction

  function automatic int clk_duty(input logic [15:0] r1, input logic [15:0] r2);
    if (r2[6]) return 500;
    return (int'(r1[11:6]) * 1000) / (int'(r1[11:6]) + int'(r1[5:0]));
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog n_checks=%0d", n_checks);
    $fatal(1);
  end

  initial begin
    int f, s, l, s0, d0;
    RST = 1'b1; SEN = 1'b0; TBL_WE = 1'b0; NUM_ENTRIES = '0;
    TBL_IDX = '0; TBL_ADDR = '0; TBL_MASK = '0; TBL_DATA = '0;
    DO = '0; DRDY = 1'b0; LOCKED = 1'b0;
    for (int i = 0; i < 128; i++) begin
      mem[i] = '0;
      shadow[i] = '0;
    end
    repeat (2) @(negedge DCLK);
    chk("rst_busy", BUSY, 0);
    chk("rst_den", DEN, 0);
    chk("rst_dwe", DWE, 0);
    chk("rst_daddr", DADDR, 0);
    chk("rst_di", DI, 0);
    chk("rst_pll_rst", PLL_RST, 0);
    chk("rst_srdy", SRDY, 0);
    chk("rst_err", ERR, 0);
    RST = 1'b0;

    tbl_write(0, 7'h08, 16'h1000, 16'h6183);
    tbl_write(1, 7'h09, 16'h0000, 16'h0043);

    // Single entry RMW
    preload(7'h08, 16'h1FFF);
    push_rmw(1);
    s0 = srdy_cnt;
    run(1, 200, f, s, l);
    chk("a_strobe_spacing", s - f, 3);
    chk("a_srdy_once", srdy_cnt - s0, 1);
    chk("a_err", ERR, 0);
    chk("a_queue_empty", exp_q.size(), 0);
    chk("a_reg08", mem[8], 16'h7183);
    chk("a_divide", clk_div(mem[8], 16'h0000), 9);
    chk("a_phase_mux", mem[8][15:13], 3);

    // Two entries in index order
    preload(7'h09, 16'hABCD);
    push_rmw(2);
    s0 = srdy_cnt;
    run(2, 200, f, s, l);
    chk("b_srdy_once", srdy_cnt - s0, 1);
    chk("b_queue_empty", exp_q.size(), 0);
    chk("b_reg09", mem[9], 16'h0043);
    chk("b_divide", clk_div(mem[8], mem[9]), 1);
    chk("b_duty", clk_duty(mem[8], mem[9]), 500);

    // DRDY never returns
    rdy_mode = c_MODE_ZERO;
    exp_q.push_back('{we: 1'b0, addr: 7'h08, di: 16'h0});
    s0 = srdy_cnt;
    run(1, 300, f, s, l);
    chk("c_err", ERR, 1);
    chk("c_pll_rst", PLL_RST, 0);
    chk("c_busy", BUSY, 0);
    chk("c_no_srdy", srdy_cnt - s0, 0);
    chk("c_timeout_span", l - f + 1, 64);
    chk("c_queue_empty", exp_q.size(), 0);
    rdy_mode = c_MODE_NORMAL;
    push_rmw(1);
    s0 = srdy_cnt;
    run(1, 200, f, s, l);
    chk("c_err_cleared", ERR, 0);
    chk("c_recover_srdy", srdy_cnt - s0, 1);

    // DRDY stuck high: guard cycle must not complete
    rdy_mode = c_MODE_ONE;
    push_rmw(1);
    s0 = srdy_cnt;
    run(1, 200, f, s, l);
    chk("d_strobe_spacing", s - f, 3);
    chk("d_srdy_once", srdy_cnt - s0, 1);
    d0 = den_cnt;
    run(0, 20, f, s, l);
    chk("d_zero_err", ERR, 1);
    chk("d_zero_no_den", den_cnt - d0, 0);
    push_rmw(1);
    run(1, 200, f, s, l);
    chk("d_err_cleared", ERR, 0);
    d0 = den_cnt;
    run(24, 20, f, s, l);
    chk("d_over_err", ERR, 1);
    chk("d_over_no_den", den_cnt - d0, 0);
    rdy_mode = c_MODE_NORMAL;
    repeat (3) @(negedge DCLK);

    // SEN and table writes while busy are ignored
    push_rmw(2);
    s0 = srdy_cnt;
    fork
      run(2, 200, f, s, l);
      begin
        repeat (4) @(negedge DCLK);
        SEN = 1'b1; TBL_WE = 1'b1; TBL_IDX = 5'd0;
        TBL_ADDR = 7'h55; TBL_MASK = 16'h0000; TBL_DATA = 16'hDEAD;
        @(negedge DCLK);
        SEN = 1'b0; TBL_WE = 1'b0;
      end
    join
    d0 = den_cnt;
    repeat (4) @(negedge DCLK);
    chk("e_srdy_once", srdy_cnt - s0, 1);
    chk("e_no_restart", den_cnt - d0, 0);
    chk("e_queue_empty", exp_q.size(), 0);
    push_rmw(1);
    run(1, 200, f, s, l);
    chk("e_table_kept", exp_q.size(), 0);

    // Reset in the middle of WRITE_WAIT
    push_rmw(1);
    @(negedge DCLK);
    NUM_ENTRIES = 6'd1;
    SEN = 1'b1;
    @(negedge DCLK);
    SEN = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (DEN && DWE) break;
      @(negedge DCLK);
    end
    chk("f_reached_write", DEN && DWE, 1);
    @(negedge DCLK);
    RST = 1'b1;
    @(negedge DCLK);
    chk("f_den", DEN, 0);
    chk("f_pll_rst", PLL_RST, 0);
    chk("f_busy", BUSY, 0);
    chk("f_err", ERR, 0);
    @(negedge DCLK);
    RST = 1'b0;
    chk("f_queue_empty", exp_q.size(), 0);
    repeat (4) @(negedge DCLK);
    push_rmw(1);
    s0 = srdy_cnt;
    run(1, 200, f, s, l);
    chk("f_after_srdy", srdy_cnt - s0, 1);
    chk("f_after_err", ERR, 0);
    chk("f_after_queue", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
